id_emit: RTL and testbench
==========================

ID_EMIT -- requirements
Module: id_emit

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock, the sole clock.
REQ-002 SHALL have ports: reset  input  1  synchronous active-high reset.
REQ-003 SHALL have ports: start  input  1  request to emit one identifier, sampled when idle.
REQ-004 SHALL have ports: letter  input  8  ASCII leading letter, latched on accepted start.
REQ-005 SHALL have ports: value  input  16  unsigned number, latched on accepted start, emitted as decimal digits.
REQ-006 SHALL have ports: char  output  8  ASCII character being offered.
REQ-007 SHALL have ports: char_valid  output  1  char holds a valid character.
REQ-008 SHALL have ports: char_ready  input  1  sink accepts char this cycle.
REQ-009 SHALL have ports: busy  output  1  high in every state except IDLE.
REQ-010 SHALL have ports: done  output  1  one-cycle pulse after the terminator transfers.
REQ-011 SHALL have ports: err  output  1  one-cycle pulse on a rejected start.

Function
REQ-012 SHALL emit, per accepted start: letter, then decimal digits of value with leading zeros suppressed (at least one digit, so 0 emits "0"), then terminator 8'h20 (space).
REQ-013 SHALL implement states IDLE, CONV, LETTER, DIGIT, TERM.
REQ-014 SHALL accept start only in IDLE; start while busy SHALL be ignored, with no effect on the latched letter/value.
REQ-015 SHALL, on accepted start with letter in "A".."Z" or "a".."z", latch letter and value and enter CONV.
REQ-016 SHALL, on start in IDLE with letter outside those ranges, stay in IDLE, emit nothing, and pulse err on the cycle after the sampling edge.
REQ-017 SHALL convert in CONV by double-dabble (shift-and-add-3) into five 4-bit BCD digits, taking exactly 16 clock cycles.
REQ-018 SHALL assert char_valid with char = letter on the cycle starting 17 edges after the edge that sampled start (LETTER state).
REQ-019 SHALL define a transfer as a rising edge with char_valid and char_ready both high.
REQ-020 SHALL hold char stable and char_valid high while char_ready is low; no character is dropped or duplicated.
REQ-021 SHALL advance LETTER -> DIGIT on transfer, starting from the most significant nonzero BCD digit (ones digit if value = 0).
REQ-022 SHALL present each digit as 8'h30 + BCD value, advancing one digit per transfer, and enter TERM after the ones digit transfers.
REQ-023 SHALL sustain one character per cycle when char_ready is held high (no idle bubbles between LETTER, DIGIT and TERM).
REQ-024 SHALL, on the terminator transfer, return to IDLE and pulse done on the following cycle; char_valid SHALL be low in that cycle.
REQ-025 SHALL accept a new start in the same cycle done is high.
REQ-026 SHALL keep char_valid low in IDLE and CONV; char value is don't-care when char_valid is low.
REQ-027 SHALL produce, for value = 65535, the full five digits "65535" (maximum length identifier: 7 characters including terminator).

Reset
REQ-028 SHALL, with reset high at a rising edge, enter IDLE with char_valid = 0, busy = 0, done = 0, err = 0, char = 8'h00.
REQ-029 SHALL give reset priority over start and char_ready in the same cycle.
REQ-030 SHALL abandon any conversion or emission on reset mid-operation, with no done pulse and no further characters.
REQ-031 SHALL come out of reset in IDLE, accepting start on the first edge with reset low.

Verification
REQ-032 SHALL cover: letter "a", value 0, char_ready = 1 -> transfers "a","0"," " on consecutive cycles from start+17, done one cycle after " ".
REQ-033 SHALL cover: letter "Z", value 65535, char_ready = 1 -> "Z","6","5","5","3","5"," " with no gaps, then done.
REQ-034 SHALL cover: letter "q", value 1002, char_ready toggled 1-0-0-1-... -> exactly "q","1","0","0","2"," " with char stable during stalls.
REQ-035 SHALL cover: letter "3" (8'h33), value 7 -> err pulse, busy stays 0, char_valid never asserts.
REQ-036 SHALL cover: reset asserted while the second digit of value 4096 is offered -> next cycle char_valid = 0, busy = 0, no done.
REQ-037 SHALL cover: start with letter "b", value 9 pulsed again during CONV with letter "c", value 5 -> only "b","9"," " emitted.

Source files
------------

// File: rtl/id_emit.sv
// Identifier emitter: prints a letter, the decimal form of a 16-bit value
// (leading zeros suppressed) and a trailing space, one character per handshake.
module id_emit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  letter,
    input  logic [15:0] value,
    output logic [7:0]  char,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CONV   = 3'd1,
        S_LETTER = 3'd2,
        S_DIGIT  = 3'd3,
        S_TERM   = 3'd4
    } state_t;

    localparam logic [4:0] CONV_STEPS = 5'd16;

    function automatic logic is_alpha(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

    // One shift-and-add-3 step; a 16-bit input never overflows five digits.
    function automatic logic [19:0] dd_step(input logic [19:0] b, input logic in_bit);
        logic [19:0] a;
        a = {add3(b[19:16]), add3(b[15:12]), add3(b[11:8]), add3(b[7:4]), add3(b[3:0])};
        return {a[18:0], in_bit};
    endfunction

    function automatic logic [3:0] nibble(input logic [19:0] b, input logic [2:0] idx);
        logic [3:0] n;
        case (idx)
            3'd4:    n = b[19:16];
            3'd3:    n = b[15:12];
            3'd2:    n = b[11:8];
            3'd1:    n = b[7:4];
            default: n = b[3:0];
        endcase
        return n;
    endfunction

    function automatic logic [2:0] msd_idx(input logic [19:0] b);
        logic [2:0] i;
        if (b[19:16] != 4'd0) begin
            i = 3'd4;
        end else if (b[15:12] != 4'd0) begin
            i = 3'd3;
        end else if (b[11:8] != 4'd0) begin
            i = 3'd2;
        end else if (b[7:4] != 4'd0) begin
            i = 3'd1;
        end else begin
            i = 3'd0;
        end
        return i;
    endfunction

    state_t      r_state;
    logic [7:0]  r_letter;
    logic [15:0] r_bin;
    logic [19:0] r_bcd;
    logic [4:0]  r_cnt;
    logic [2:0]  r_dig;
    logic [7:0]  r_char;
    logic        r_char_valid;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    state_t      w_state_nxt;
    logic [2:0]  w_dig_nxt;
    logic        w_accept;
    logic        w_reject;
    logic        w_done_nxt;
    logic        w_xfer;
    logic [7:0]  w_char_nxt;
    logic        w_valid_nxt;

    assign w_xfer = r_char_valid & char_ready;

    // Next-state and digit-index selection.
    always_comb begin
        w_state_nxt = r_state;
        w_dig_nxt   = r_dig;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (is_alpha(letter)) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_CONV;
                    end else begin
                        w_reject    = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CONV: begin
                // Extra cycle after the last shift picks the leading digit.
                if (r_cnt == CONV_STEPS) begin
                    w_state_nxt = S_LETTER;
                    w_dig_nxt   = msd_idx(r_bcd);
                end else begin
                    w_state_nxt = S_CONV;
                end
            end
            S_LETTER: begin
                if (w_xfer) begin
                    w_state_nxt = S_DIGIT;
                end else begin
                    w_state_nxt = S_LETTER;
                end
            end
            S_DIGIT: begin
                if (w_xfer) begin
                    if (r_dig == 3'd0) begin
                        w_state_nxt = S_TERM;
                    end else begin
                        w_dig_nxt   = r_dig - 3'd1;
                    end
                end else begin
                    w_state_nxt = S_DIGIT;
                end
            end
            S_TERM: begin
                if (w_xfer) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_TERM;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Character offered in the coming cycle, decoded from the next state.
    always_comb begin
        w_char_nxt  = 8'h00;
        w_valid_nxt = 1'b0;
        case (w_state_nxt)
            S_LETTER: begin
                w_char_nxt  = r_letter;
                w_valid_nxt = 1'b1;
            end
            S_DIGIT: begin
                w_char_nxt  = 8'h30 + {4'h0, nibble(r_bcd, w_dig_nxt)};
                w_valid_nxt = 1'b1;
            end
            S_TERM: begin
                w_char_nxt  = 8'h20;
                w_valid_nxt = 1'b1;
            end
            default: begin
                w_char_nxt  = 8'h00;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_letter     <= 8'h00;
            r_bin        <= 16'h0000;
            r_bcd        <= 20'h00000;
            r_cnt        <= 5'd0;
            r_dig        <= 3'd0;
            r_char       <= 8'h00;
            r_char_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_dig        <= w_dig_nxt;
            r_char       <= w_char_nxt;
            r_char_valid <= w_valid_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_done       <= w_done_nxt;
            r_err        <= w_reject;
            if (w_accept) begin
                r_letter <= letter;
                r_bin    <= value;
                r_bcd    <= 20'h00000;
                r_cnt    <= 5'd0;
            end else if ((r_state == S_CONV) && (r_cnt != CONV_STEPS)) begin
                r_bcd    <= dd_step(r_bcd, r_bin[15]);
                r_bin    <= {r_bin[14:0], 1'b0};
                r_cnt    <= r_cnt + 5'd1;
            end else begin
                r_bcd    <= r_bcd;
            end
        end
    end

    assign char       = r_char;
    assign char_valid = r_char_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_id_emit.sv
// Directed bench for id_emit: expected characters are queued at launch and
// popped by a monitor whenever a transfer is about to happen.
module tb_id_emit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  letter;
    logic [15:0] value;
    logic [7:0]  char;
    logic        char_valid;
    logic        char_ready;
    logic        busy;
    logic        done;
    logic        err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  sb[$];
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_char  = 8'h00;

    id_emit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .letter     (letter),
        .value      (value),
        .char       (char),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge when valid & ready.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, char_valid}, 32'd1);
                check("stall_char", {24'd0, char}, {24'd0, prev_char});
            end
            if (char_valid && char_ready) begin
                n_checks++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_char: observed %0h expected none", char);
                end
                if (sb.size() != 0) begin
                    check("char", {24'd0, char}, {24'd0, sb.pop_front()});
                end
            end
            prev_stall = char_valid && !char_ready;
            prev_char  = char;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_exp(input logic [7:0] l, input logic [15:0] v);
        string s;
        sb.push_back(l);
        s = $sformatf("%0d", v);
        foreach (s[i]) sb.push_back(s[i]);
        sb.push_back(8'h20);
    endtask

    task automatic launch(input logic [7:0] l, input logic [15:0] v);
        letter = l;
        value  = v;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        letter = 8'h2A;
        value  = 16'hBEEF;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!char_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_done(input int mode, output int n);
        n = 0;
        while (!done && n < 80) begin
            @(posedge clk); #1;
            n++;
            char_ready = (mode == 0) ? 1'b1 : ((n % 3) == 0);
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("done_valid_low", {31'd0, char_valid}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);
        char_ready = 1'b1;
    endtask

    initial begin
        int n;
        int bad;
        reset = 1'b1; start = 1'b0; letter = 8'h00; value = 16'h0000; char_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, char_valid}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        check("rst_char",  {24'd0, char}, 32'h00);
        reset = 1'b0;

        // "a", 0 -> "a0 "
        push_exp(8'h61, 16'd0);
        launch(8'h61, 16'd0);
        check("a0_busy", {31'd0, busy}, 32'd1);
        wait_valid(n);
        check("a0_latency", n, 32'd17);
        check("a0_first", {24'd0, char}, 32'h61);
        wait_done(0, n);
        check("a0_done_cycles", n, 32'd3);
        check("a0_busy_after", {31'd0, busy}, 32'd0);

        // "Z", 65535 -> "Z65535 " back to back, launched in the done cycle
        push_exp(8'h5A, 16'd65535);
        launch(8'h5A, 16'd65535);
        wait_valid(n);
        check("z_latency", n, 32'd17);
        wait_done(0, n);
        check("z_done_cycles", n, 32'd7);

        // "q", 1002 with stalls
        push_exp(8'h71, 16'd1002);
        launch(8'h71, 16'd1002);
        wait_valid(n);
        check("q_latency", n, 32'd17);
        wait_done(1, n);

        // Non-letter start is rejected
        launch(8'h33, 16'd7);
        check("e_err", {31'd0, err}, 32'd1);
        check("e_busy", {31'd0, busy}, 32'd0);
        check("e_valid", {31'd0, char_valid}, 32'd0);
        @(posedge clk); #1;
        check("e_err_pulse", {31'd0, err}, 32'd0);
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (char_valid || busy) bad++;
        end
        check("e_quiet", bad, 32'd0);

        // Reset while the second digit of 4096 is offered
        sb.push_back(8'h77);
        sb.push_back(8'h34);
        launch(8'h77, 16'd4096);
        wait_valid(n);
        check("r_latency", n, 32'd17);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("r_second_digit", {24'd0, char}, 32'h30);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("r_valid", {31'd0, char_valid}, 32'd0);
        check("r_busy", {31'd0, busy}, 32'd0);
        check("r_done", {31'd0, done}, 32'd0);
        bad = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done || char_valid) bad++;
        end
        check("r_quiet", bad, 32'd0);
        check("r_sb_empty", sb.size(), 32'd0);

        // Start during CONV is ignored
        push_exp(8'h62, 16'd9);
        launch(8'h62, 16'd9);
        letter = 8'h63; value = 16'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b_busy", {31'd0, busy}, 32'd1);
        wait_valid(n);
        check("b_latency", n, 32'd16);
        wait_done(0, n);
        check("b_done_cycles", n, 32'd3);

        // Reset beats start; first edge with reset low accepts start
        reset = 1'b1; start = 1'b1; letter = 8'h6B; value = 16'd12;
        @(posedge clk); #1;
        check("p_busy_in_reset", {31'd0, busy}, 32'd0);
        push_exp(8'h6B, 16'd12);
        reset = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("p_busy_after", {31'd0, busy}, 32'd1);
        wait_valid(n);
        check("p_latency", n, 32'd17);
        wait_done(0, n);
        check("p_done_cycles", n, 32'd4);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
